// File: rtl/uart_tx_periph_pkg.sv
// ============================================================================
//  Module      : uart_tx_periph_pkg
//  Description : Register offsets, status bit positions and divisor helper
//                shared by the UART transmitter peripheral.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_periph_pkg;

    // Register offsets decoded from addr[4:3]
    typedef enum logic [1:0] {
        REG_TXDATA  = 2'd0,
        REG_STATUS  = 2'd1,
        REG_BAUDDIV = 2'd2,
        REG_RSVD    = 2'd3
    } reg_off_e;

    localparam int c_DIV_W = 16;

    // A divisor of zero would stall the baud counter, so it is promoted to 1
    function automatic logic [c_DIV_W-1:0] fix_div(input logic [c_DIV_W-1:0] d);
        return (d == '0) ? c_DIV_W'(1) : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_periph_if.sv
// ============================================================================
//  Module      : uart_tx_periph_if
//  Description : Data-bus slave port of the UART window (select, direction,
//                address, write data, registered read data, exception).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_periph_if;
    logic        sel;
    logic        rw;
    logic [63:0] addr;
    logic [63:0] write;
    logic [63:0] read;
    logic        exception;

    modport master (output sel, rw, addr, write, input read, exception);
    modport slave  (input sel, rw, addr, write, output read, exception);
endinterface

`default_nettype wire

// File: rtl/uart_tx_periph_sync_fifo.sv
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock show-ahead FIFO. Push while full and pop while
//                empty are ignored; full/empty come from pre-cycle state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push,
    input  wire logic                   pop,
    input  wire logic [WIDTH-1:0]       din,
    output logic      [WIDTH-1:0]       dout,
    output logic                        full,
    output logic                        empty,
    output logic      [$clog2(DEPTH):0] count
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (c_AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: rtl/uart_tx_periph.sv
// ============================================================================
//  Module      : uart_tx_periph
//  Description : Memory-mapped 8N1 UART transmitter with TX FIFO, status and
//                programmable baud divisor. Optional interrupt output and
//                BAUDDIV bit16 enable under ZIPOSOC_UART_IRQ_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 217
) (
    input  wire logic        clk,
    input  wire logic        rst,
    uart_tx_periph_if.slave  bus,
    output logic             tx
`ifdef ZIPOSOC_UART_IRQ_EN
   ,output logic             irq
`endif
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;
    localparam int         c_CW    = $clog2(FIFO_DEPTH) + 1;

    reg_off_e           w_off;
    logic               w_wr, w_rd, w_push, w_pop, w_exc;
    logic               w_full, w_empty, w_busy, w_irq_en, w_line, w_baud_done;
    logic [7:0]         w_dout;
    logic [c_CW-1:0]    w_count;
    logic [63:0]        w_status, w_rdata;
    logic [1:0]         r_state;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit;
    logic [c_DIV_W-1:0] r_div, r_fdiv, r_baud;
    logic               r_tx, r_exc;
    logic [63:0]        r_read;
    logic               w_unused;

    assign w_off       = reg_off_e'(bus.addr[4:3]);
    assign w_wr        = bus.sel && bus.rw;
    assign w_rd        = bus.sel && !bus.rw;
    assign w_push      = w_wr && (w_off == REG_TXDATA) && !w_full;
    assign w_exc       = bus.sel && ((w_off == REG_RSVD) ||
                                     (w_wr && (w_off == REG_STATUS)) ||
                                     (w_wr && (w_off == REG_TXDATA) && w_full));
    assign w_busy      = (r_state != c_IDLE);
    assign w_baud_done = (r_baud == '0);
    // Pop from IDLE, or in the last STOP cycle so frames run back to back
    assign w_pop       = !w_empty && ((r_state == c_IDLE) ||
                                      ((r_state == c_STOP) && w_baud_done));
    assign w_unused    = &{1'b0, bus.addr[63:5], bus.addr[2:0], bus.write[63:17],
                           bus.write[16]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.write[7:0]),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

`ifdef ZIPOSOC_UART_IRQ_EN
    logic r_irq_en, r_irq;
    // Interrupt enable lives in BAUDDIV bit16
    always_ff @(posedge clk) begin
        if (rst) r_irq_en <= 1'b0;
        else if (w_wr && (w_off == REG_BAUDDIV)) r_irq_en <= bus.write[16];
    end
    // Transmitter fully drained: nothing queued and no frame on the line
    always_ff @(posedge clk) begin
        if (rst) r_irq <= 1'b0;
        else     r_irq <= r_irq_en && w_empty && !w_busy;
    end
    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
`endif

    assign w_status = {48'b0, w_irq_en, 7'(w_count), 5'b0, w_busy, w_empty, w_full};

    // Read data selection by register offset
    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_STATUS:  w_rdata = w_status;
            REG_BAUDDIV: w_rdata = {47'b0, w_irq_en, r_div};
            default:     w_rdata = '0;
        endcase
    end

    // Registered read data and one-cycle exception pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_read <= '0;
            r_exc  <= 1'b0;
        end else begin
            r_exc <= w_exc;
            if (w_rd && (w_off != REG_RSVD)) r_read <= w_rdata;
        end
    end

    // Programmable divisor; applied at the next frame start
    always_ff @(posedge clk) begin
        if (rst) r_div <= c_DIV_W'(DEFAULT_DIV);
        else if (w_wr && (w_off == REG_BAUDDIV)) r_div <= fix_div(bus.write[15:0]);
    end

    // Line level for the current state, registered onto tx below
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            c_START: w_line = 1'b0;
            c_DATA:  w_line = r_shift[0];
            default: w_line = 1'b1;
        endcase
    end

    // Baud-rate state machine serialising 8N1 frames
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
            r_fdiv  <= c_DIV_W'(DEFAULT_DIV);
            r_tx    <= 1'b1;
        end else begin
            r_tx <= w_line;
            if (w_pop) begin
                r_shift <= w_dout;
                r_fdiv  <= r_div;
                r_baud  <= r_div - c_DIV_W'(1);
                r_state <= c_START;
            end else begin
                case (r_state)
                    c_START: begin
                        if (w_baud_done) begin
                            r_baud  <= r_fdiv - c_DIV_W'(1);
                            r_bit   <= '0;
                            r_state <= c_DATA;
                        end else r_baud <= r_baud - c_DIV_W'(1);
                    end
                    c_DATA: begin
                        if (w_baud_done) begin
                            r_baud  <= r_fdiv - c_DIV_W'(1);
                            r_shift <= r_shift >> 1;
                            if (r_bit == 3'd7) r_state <= c_STOP;
                            else               r_bit   <= r_bit + 3'd1;
                        end else r_baud <= r_baud - c_DIV_W'(1);
                    end
                    c_STOP: begin
                        if (w_baud_done) r_state <= c_IDLE;
                        else             r_baud  <= r_baud - c_DIV_W'(1);
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign tx            = r_tx;
    assign bus.read      = r_read;
    assign bus.exception = r_exc;
endmodule

`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
// ============================================================================
//  Module      : tb_uart_tx_periph
//  Description : Self-checking bench for uart_tx_periph. Bytes written to
//                TXDATA are queued as expected and compared against frames
//                decoded from tx. Build with ZIPOSOC_UART_IRQ_EN for irq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_periph;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
`ifdef ZIPOSOC_UART_IRQ_EN
    logic irq;
`endif

    uart_tx_periph_if bus ();

    uart_tx_periph #(.FIFO_DEPTH(8), .DEFAULT_DIV(217)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .tx  (tx)
`ifdef ZIPOSOC_UART_IRQ_EN
       ,.irq (irq)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          cur_div  = 4;
    bit          mon_en   = 1'b1;
    bit          mon_busy = 1'b0;
    logic [7:0]  exp_q[$];
    int          start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [63:0] data);
        @(negedge clk);
        bus.sel = 1'b1; bus.rw = 1'b1; bus.addr = {59'b0, off, 3'b0}; bus.write = data;
        @(negedge clk);
        bus.sel = 1'b0; bus.rw = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] off, output logic [63:0] data);
        @(negedge clk);
        bus.sel = 1'b1; bus.rw = 1'b0; bus.addr = {59'b0, off, 3'b0};
        @(negedge clk);
        bus.sel = 1'b0;
        data = bus.read;
    endtask

    task automatic read_check(input string tag, input logic [1:0] off, input logic [63:0] exp);
        logic [63:0] d;
        bus_read(off, d);
        check(tag, d, exp);
    endtask

    // Exception must be high now (cycle after sel) and low the cycle after
    task automatic exc_pulse(input string tag);
        check({tag, "_hi"}, bus.exception, 1);
        @(negedge clk);
        check({tag, "_lo"}, bus.exception, 0);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (exp_q.size() != 0 || mon_busy), 0);
    endtask

    // Frame monitor: detect start bit, sample mid-bit, compare with scoreboard
    always begin
        logic [7:0] rx;
        int d;
        @(negedge clk);
        if (!rst && mon_en && tx === 1'b0) begin
            mon_busy = 1'b1;
            start_q.push_back(cyc);
            d = cur_div;
            repeat ((d - 1) / 2) @(negedge clk);
            check("mon_start", tx, 0);
            for (int b = 0; b < 8; b++) begin
                repeat (d) @(negedge clk);
                rx[b] = tx;
            end
            repeat (d) @(negedge clk);
            check("mon_stop", tx, 1);
            if (exp_q.size() == 0) check("mon_unexpected_frame", rx, 'x);
            else                   check("mon_byte", rx, exp_q.pop_front());
            repeat (d - 1 - (d - 1) / 2) @(negedge clk);
            mon_busy = 1'b0;
        end
    end

    initial begin
        logic [9:0] a5_bits;
        bus.sel = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.write = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_read", bus.read, 0);
        check("rst_exc", bus.exception, 0);
        check("rst_tx", tx, 1);
        read_check("rst_status", 2'd1, 64'h2);
        read_check("rst_div", 2'd2, 64'd217);
        read_check("txdata_reads0", 2'd0, 64'h0);

        // DIV=4, single 0xA5 frame checked cycle by cycle
        bus_write(2'd2, 64'd4);
        read_check("div4_rb", 2'd2, 64'd4);
        cur_div = 4;
        a5_bits = 10'b1_1010_0101_0;   // stop, data MSB..LSB, start
        exp_q.push_back(8'hA5);
        bus_write(2'd0, 64'hA5);
        check("a5_count1", dut.w_count, 1);
        @(negedge clk);
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    check($sformatf("a5_tx%0d", i), tx, a5_bits[i / 4]);
                    @(negedge clk);
                end
            end
            begin
                logic [63:0] s;
                repeat (16) @(negedge clk);
                bus_read(2'd1, s);
                check("a5_busy_mid", s[2], 1);
            end
        join
        wait_drain(100);
        read_check("a5_status_after", 2'd1, 64'h2);

        // Illegal accesses: exception pulses, no state change
        bus_write(2'd3, 64'h55);
        exc_pulse("wr_rsvd");
        bus_read(2'd3, a5_bits);
        exc_pulse("rd_rsvd");
        bus_write(2'd1, 64'hFFFF);
        exc_pulse("wr_status");
        read_check("illegal_status", 2'd1, 64'h2);
        read_check("illegal_div", 2'd2, 64'd4);

        // Back-to-back burst: 9 accepted, 2 dropped while full
        start_q.delete();
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) check($sformatf("burst_exc%0d", i - 1), bus.exception, (i - 1) >= 9);
            bus.sel = 1'b1; bus.rw = 1'b1; bus.addr = '0; bus.write = 64'(i);
            if (i < 9) exp_q.push_back(8'(i));
            @(negedge clk);
        end
        bus.sel = 1'b0; bus.rw = 1'b0;
        check("burst_exc10", bus.exception, 1);
        check("burst_full_count", dut.w_count, 8);
        wait_drain(1000);
        check("burst_frames", start_q.size(), 9);
        for (int k = 1; k < start_q.size(); k++)
            check($sformatf("burst_gap%0d", k), start_q[k] - start_q[k - 1], 40);

        // Divisor 0 is stored as 1; one-cycle bits
        bus_write(2'd2, 64'd0);
        read_check("div0_rb", 2'd2, 64'd1);
        cur_div = 1;
        exp_q.push_back(8'h5A);
        bus_write(2'd0, 64'h5A);
        wait_drain(100);
        exp_q.push_back(8'h81);
        bus_write(2'd0, 64'h81);
        wait_drain(100);

        // Reset during DATA aborts the frame
        mon_en = 1'b0;
        bus_write(2'd2, 64'd4);
        bus_write(2'd0, 64'hC3);
        repeat (14) @(negedge clk);
        check("pre_rst_busy", dut.w_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_abort_tx%0d", i), tx, 1);
            if (i < 3) @(negedge clk);
        end
        read_check("rst_abort_status", 2'd1, 64'h2);
        read_check("rst_abort_div", 2'd2, 64'd217);
        mon_en = 1'b1;

`ifdef ZIPOSOC_UART_IRQ_EN
        bus_write(2'd2, 64'h1_0004);
        cur_div = 4;
        read_check("irq_div_rb", 2'd2, 64'h1_0004);
        read_check("irq_status", 2'd1, 64'h8002);
        check("irq_idle_hi", irq, 1);
        exp_q.push_back(8'h3C);
        bus_write(2'd0, 64'h3C);
        @(negedge clk);
        check("irq_cleared", irq, 0);
        wait_drain(100);
        check("irq_after_stop", irq, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog in case something stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

`default_nettype wire
